// File: rtl/cmp_result_collector.sv
// cmp_result_collector
// Collects statistics on a stream of comparator gr/ls/eq flags over a
// programmable window of valid samples, then holds the report until it is
// accepted through a valid/ready handshake.
//
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset
//   start           begin a window (sampled in IDLE only)
//   window_len      number of valid samples per window, latched on start
//   in_valid        gr/ls/eq carry a sample this cycle
//   gr, ls, eq      comparator flags
//   busy            high while collecting or reporting
//   report_valid    report fields valid, held until report_ready
//   report_ready    downstream accepts the report
//   cnt_gr/ls/eq    counts of legal one-hot samples per outcome
//   cnt_err         count of samples that were not exactly one-hot
//   max_eq_run      longest run of consecutive valid eq samples
module cmp_result_collector #(
  parameter int unsigned CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [CW-1:0] window_len,
  input  logic          in_valid,
  input  logic          gr,
  input  logic          ls,
  input  logic          eq,
  output logic          busy,
  output logic          report_valid,
  input  logic          report_ready,
  output logic [CW-1:0] cnt_gr,
  output logic [CW-1:0] cnt_ls,
  output logic [CW-1:0] cnt_eq,
  output logic [CW-1:0] cnt_err,
  output logic [CW-1:0] max_eq_run
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_REPORT  = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic          busy_q, busy_d;
  logic          report_valid_q, report_valid_d;
  logic [CW-1:0] cnt_gr_q, cnt_gr_d;
  logic [CW-1:0] cnt_ls_q, cnt_ls_d;
  logic [CW-1:0] cnt_eq_q, cnt_eq_d;
  logic [CW-1:0] cnt_err_q, cnt_err_d;
  logic [CW-1:0] max_eq_run_q, max_eq_run_d;
  logic [CW-1:0] run_q, run_d;
  logic [CW-1:0] remaining_q, remaining_d;

  logic          start_acc_c;
  logic          sample_c;
  logic          last_c;
  logic          legal_c;
  logic [CW-1:0] run_inc_c;

  // Event decode shared by the FSM and datapath
  always_comb begin
    start_acc_c = (state_q == S_IDLE) && start && (window_len != '0);
    sample_c    = (state_q == S_COLLECT) && in_valid;
    last_c      = sample_c && (remaining_q == CW'(1));
    run_inc_c   = run_q + CW'(1);
    legal_c     = 1'b0;
    case ({gr, ls, eq})
      3'b100, 3'b010, 3'b001: legal_c = 1'b1;
      default:                legal_c = 1'b0;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start_acc_c) state_d = S_COLLECT;
      end
      S_COLLECT: begin
        if (last_c) state_d = S_REPORT;
      end
      S_REPORT: begin
        // report_valid is high throughout REPORT, so ready alone completes it
        if (report_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Status outputs, registered from the next state so they track state_q
  always_comb begin
    busy_d         = 1'b0;
    report_valid_d = 1'b0;
    case (state_d)
      S_COLLECT: busy_d = 1'b1;
      S_REPORT: begin
        busy_d         = 1'b1;
        report_valid_d = 1'b1;
      end
      default: begin
        busy_d         = 1'b0;
        report_valid_d = 1'b0;
      end
    endcase
  end

  // Counter / run-length datapath
  always_comb begin
    cnt_gr_d     = cnt_gr_q;
    cnt_ls_d     = cnt_ls_q;
    cnt_eq_d     = cnt_eq_q;
    cnt_err_d    = cnt_err_q;
    max_eq_run_d = max_eq_run_q;
    run_d        = run_q;
    remaining_d  = remaining_q;

    if (start_acc_c) begin
      cnt_gr_d     = '0;
      cnt_ls_d     = '0;
      cnt_eq_d     = '0;
      cnt_err_d    = '0;
      max_eq_run_d = '0;
      run_d        = '0;
      remaining_d  = window_len;
    end else if (sample_c) begin
      remaining_d = remaining_q - CW'(1);
      if (legal_c && eq) begin
        cnt_eq_d = cnt_eq_q + CW'(1);
        run_d    = run_inc_c;
        if (run_inc_c > max_eq_run_q) max_eq_run_d = run_inc_c;
      end else begin
        // Any non-eq valid sample, legal or not, breaks the eq run
        run_d = '0;
        if (!legal_c)  cnt_err_d = cnt_err_q + CW'(1);
        else if (gr)   cnt_gr_d  = cnt_gr_q + CW'(1);
        else           cnt_ls_d  = cnt_ls_q + CW'(1);
      end
    end
  end

  // Datapath and status registers
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q         <= 1'b0;
      report_valid_q <= 1'b0;
      cnt_gr_q       <= '0;
      cnt_ls_q       <= '0;
      cnt_eq_q       <= '0;
      cnt_err_q      <= '0;
      max_eq_run_q   <= '0;
      run_q          <= '0;
      remaining_q    <= '0;
    end else begin
      busy_q         <= busy_d;
      report_valid_q <= report_valid_d;
      cnt_gr_q       <= cnt_gr_d;
      cnt_ls_q       <= cnt_ls_d;
      cnt_eq_q       <= cnt_eq_d;
      cnt_err_q      <= cnt_err_d;
      max_eq_run_q   <= max_eq_run_d;
      run_q          <= run_d;
      remaining_q    <= remaining_d;
    end
  end

  assign busy         = busy_q;
  assign report_valid = report_valid_q;
  assign cnt_gr       = cnt_gr_q;
  assign cnt_ls       = cnt_ls_q;
  assign cnt_eq       = cnt_eq_q;
  assign cnt_err      = cnt_err_q;
  assign max_eq_run   = max_eq_run_q;

endmodule

// File: tb/tb_cmp_result_collector.sv
// Directed bench for cmp_result_collector: reset, basic window, illegal
// encodings with gaps, handshake hold, full-scale window, mid-window reset.
module tb_cmp_result_collector;

  localparam int unsigned CW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [CW-1:0] window_len;
  logic          in_valid;
  logic          gr, ls, eq;
  logic          busy;
  logic          report_valid;
  logic          report_ready;
  logic [CW-1:0] cnt_gr, cnt_ls, cnt_eq, cnt_err, max_eq_run;

  int n_cmp = 0;
  int n_bad = 0;

  cmp_result_collector #(.CW(CW)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .window_len   (window_len),
    .in_valid     (in_valid),
    .gr           (gr),
    .ls           (ls),
    .eq           (eq),
    .busy         (busy),
    .report_valid (report_valid),
    .report_ready (report_ready),
    .cnt_gr       (cnt_gr),
    .cnt_ls       (cnt_ls),
    .cnt_eq       (cnt_eq),
    .cnt_err      (cnt_err),
    .max_eq_run   (max_eq_run)
  );

  always #5 clk = ~clk;

  // Inputs change on the falling edge; outputs are read on the falling edge
  task automatic drive(input logic iv, input logic g, input logic l, input logic e);
    in_valid = iv; gr = g; ls = l; eq = e;
    @(negedge clk);
  endtask

  task automatic begin_window(input logic [CW-1:0] len);
    start = 1'b1; window_len = len; in_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %0b want 0", busy); end
    n_cmp++; if (report_valid !== 1'b0) begin n_bad++; $display("FAIL reset_rv: got %0b want 0", report_valid); end
    n_cmp++; if ({cnt_gr, cnt_ls, cnt_eq, cnt_err, max_eq_run} !== 40'h0) begin
      n_bad++; $display("FAIL reset_counts: got %0d/%0d/%0d/%0d/%0d want all 0",
                        cnt_gr, cnt_ls, cnt_eq, cnt_err, max_eq_run);
    end
    rst = 1'b0;
    begin_window(8'd0);
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL zero_len_busy: got %0b want 0", busy); end
  endtask

  task automatic test_basic;
    begin_window(8'd5);
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL basic_busy: got %0b want 1", busy); end
    drive(1, 1, 0, 0);
    drive(1, 0, 1, 0);
    drive(1, 0, 0, 1);
    drive(1, 0, 0, 1);
    n_cmp++; if (report_valid !== 1'b0) begin n_bad++; $display("FAIL basic_rv_early: got %0b want 0", report_valid); end
    drive(1, 1, 0, 0);
    in_valid = 1'b0;
    n_cmp++; if (report_valid !== 1'b1) begin n_bad++; $display("FAIL basic_rv: got %0b want 1", report_valid); end
    n_cmp++; if (cnt_gr !== 8'd2) begin n_bad++; $display("FAIL basic_gr: got %0d want 2", cnt_gr); end
    n_cmp++; if (cnt_ls !== 8'd1) begin n_bad++; $display("FAIL basic_ls: got %0d want 1", cnt_ls); end
    n_cmp++; if (cnt_eq !== 8'd2) begin n_bad++; $display("FAIL basic_eq: got %0d want 2", cnt_eq); end
    n_cmp++; if (cnt_err !== 8'd0) begin n_bad++; $display("FAIL basic_err: got %0d want 0", cnt_err); end
    n_cmp++; if (max_eq_run !== 8'd2) begin n_bad++; $display("FAIL basic_run: got %0d want 2", max_eq_run); end
    report_ready = 1'b1;
    @(negedge clk);
    report_ready = 1'b0;
    n_cmp++; if (report_valid !== 1'b0 || busy !== 1'b0) begin
      n_bad++; $display("FAIL basic_accept: got rv=%0b busy=%0b want 0/0", report_valid, busy);
    end
  endtask

  task automatic test_illegal_gaps;
    begin_window(8'd6);
    n_cmp++; if (cnt_gr !== 8'd0) begin n_bad++; $display("FAIL ill_clear_gr: got %0d want 0", cnt_gr); end
    drive(1, 0, 0, 1);
    drive(1, 0, 0, 1);
    drive(0, 1, 0, 0);
    drive(0, 0, 1, 1);
    drive(0, 1, 1, 1);
    drive(1, 0, 0, 1);
    drive(1, 1, 1, 0);
    drive(1, 0, 0, 1);
    n_cmp++; if (report_valid !== 1'b0) begin n_bad++; $display("FAIL ill_rv_early: got %0b want 0", report_valid); end
    drive(1, 0, 0, 0);
    in_valid = 1'b0;
    n_cmp++; if (report_valid !== 1'b1) begin n_bad++; $display("FAIL ill_rv: got %0b want 1", report_valid); end
    n_cmp++; if (cnt_eq !== 8'd4) begin n_bad++; $display("FAIL ill_eq: got %0d want 4", cnt_eq); end
    n_cmp++; if (cnt_err !== 8'd2) begin n_bad++; $display("FAIL ill_err: got %0d want 2", cnt_err); end
    n_cmp++; if (cnt_gr !== 8'd0 || cnt_ls !== 8'd0) begin
      n_bad++; $display("FAIL ill_grls: got %0d/%0d want 0/0", cnt_gr, cnt_ls);
    end
    n_cmp++; if (max_eq_run !== 8'd3) begin n_bad++; $display("FAIL ill_run: got %0d want 3", max_eq_run); end
  endtask

  // Runs on the report left pending by test_illegal_gaps
  task automatic test_handshake;
    for (int i = 0; i < 10; i++) begin
      logic [3:0] v;
      v = 4'(i + 5);
      start = v[0]; window_len = 8'd4;
      drive(v[1], v[2], v[3], v[0]);
      n_cmp++; if (report_valid !== 1'b1 || busy !== 1'b1) begin
        n_bad++; $display("FAIL hold_rv[%0d]: got rv=%0b busy=%0b want 1/1", i, report_valid, busy);
      end
      n_cmp++; if (cnt_eq !== 8'd4 || cnt_err !== 8'd2 || max_eq_run !== 8'd3 ||
                   cnt_gr !== 8'd0 || cnt_ls !== 8'd0) begin
        n_bad++; $display("FAIL hold_fields[%0d]: got %0d/%0d/%0d/%0d/%0d want 0/0/4/2/3",
                          i, cnt_gr, cnt_ls, cnt_eq, cnt_err, max_eq_run);
      end
    end
    start = 1'b1; window_len = 8'd3; in_valid = 1'b0; report_ready = 1'b1;
    @(negedge clk);
    start = 1'b0; report_ready = 1'b0;
    n_cmp++; if (report_valid !== 1'b0 || busy !== 1'b0) begin
      n_bad++; $display("FAIL hs_accept: got rv=%0b busy=%0b want 0/0", report_valid, busy);
    end
    n_cmp++; if (cnt_eq !== 8'd4 || cnt_err !== 8'd2 || max_eq_run !== 8'd3) begin
      n_bad++; $display("FAIL hs_retain: got eq=%0d err=%0d run=%0d want 4/2/3", cnt_eq, cnt_err, max_eq_run);
    end
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL hs_start_ignored: got busy=%0b want 0", busy); end
  endtask

  task automatic test_full_scale;
    begin_window(8'd255);
    repeat (254) drive(1, 0, 0, 1);
    n_cmp++; if (report_valid !== 1'b0) begin n_bad++; $display("FAIL full_rv_early: got %0b want 0", report_valid); end
    drive(1, 0, 0, 1);
    in_valid = 1'b0;
    n_cmp++; if (report_valid !== 1'b1) begin n_bad++; $display("FAIL full_rv: got %0b want 1", report_valid); end
    n_cmp++; if (cnt_eq !== 8'd255) begin n_bad++; $display("FAIL full_eq: got %0d want 255", cnt_eq); end
    n_cmp++; if (max_eq_run !== 8'd255) begin n_bad++; $display("FAIL full_run: got %0d want 255", max_eq_run); end
    n_cmp++; if (cnt_err !== 8'd0) begin n_bad++; $display("FAIL full_err: got %0d want 0", cnt_err); end
    report_ready = 1'b1;
    @(negedge clk);
    report_ready = 1'b0;
  endtask

  task automatic test_reset_mid;
    begin_window(8'd8);
    drive(1, 1, 0, 0);
    drive(1, 0, 0, 1);
    drive(1, 0, 1, 0);
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_cmp++; if (busy !== 1'b0 || report_valid !== 1'b0) begin
      n_bad++; $display("FAIL mid_rst_state: got busy=%0b rv=%0b want 0/0", busy, report_valid);
    end
    n_cmp++; if ({cnt_gr, cnt_ls, cnt_eq, cnt_err, max_eq_run} !== 40'h0) begin
      n_bad++; $display("FAIL mid_rst_counts: got %0d/%0d/%0d/%0d/%0d want all 0",
                        cnt_gr, cnt_ls, cnt_eq, cnt_err, max_eq_run);
    end
    report_ready = 1'b1;
    begin_window(8'd2);
    drive(1, 0, 1, 0);
    drive(1, 0, 1, 0);
    in_valid = 1'b0;
    n_cmp++; if (report_valid !== 1'b1) begin n_bad++; $display("FAIL mid_rv: got %0b want 1", report_valid); end
    n_cmp++; if (cnt_ls !== 8'd2 || cnt_gr !== 8'd0 || cnt_eq !== 8'd0 ||
                 cnt_err !== 8'd0 || max_eq_run !== 8'd0) begin
      n_bad++; $display("FAIL mid_counts: got %0d/%0d/%0d/%0d/%0d want 0/2/0/0/0",
                        cnt_gr, cnt_ls, cnt_eq, cnt_err, max_eq_run);
    end
    @(negedge clk);
    report_ready = 1'b0;
    n_cmp++; if (report_valid !== 1'b0 || busy !== 1'b0) begin
      n_bad++; $display("FAIL mid_pulse: got rv=%0b busy=%0b want 0/0", report_valid, busy);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; window_len = '0; in_valid = 1'b0;
    gr = 1'b0; ls = 1'b0; eq = 1'b0; report_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_illegal_gaps();
    test_handshake();
    test_full_scale();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cmp_result_collector.md
Name: cmp_result_collector

Overview:
- Downstream consumer of the n-bit comparator's gr/ls/eq flags.
- Over a programmable window of N valid samples it counts gr, ls and eq outcomes, counts illegal flag encodings, and tracks the longest run of consecutive eq samples.
- It then presents a report held under a valid/ready handshake.
- It lets the comparator stream be checked in hardware instead of by waveform inspection.

Parameters:
- CW, 8, width of window length, all counters and max-run output; window max 2^CW-1 samples.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- start  input  1  begin a window; sampled only in IDLE
- window_len  input  CW  number of valid samples in window; latched on accepted start
- in_valid  input  1  gr/ls/eq carry a sample this cycle
- gr  input  1  comparator a>b flag
- ls  input  1  comparator a<b flag
- eq  input  1  comparator a==b flag
- busy  output  1  high in COLLECT and REPORT
- report_valid  output  1  report fields valid, held until accepted
- report_ready  input  1  downstream accepts report
- cnt_gr  output  CW  count of legal gr samples
- cnt_ls  output  CW  count of legal ls samples
- cnt_eq  output  CW  count of legal eq samples
- cnt_err  output  CW  count of samples not exactly one-hot
- max_eq_run  output  CW  longest run of consecutive valid eq samples

Behaviour:
- Reset (rst=1 at a clock edge, any state, including mid-window or mid-report):
  - state=IDLE, all counters, max_eq_run and internal run/remaining registers = 0.
  - busy=0, report_valid=0.
- FSM states: IDLE, COLLECT, REPORT.
- IDLE:
  - start=1 and window_len!=0 at an edge -> COLLECT. Same edge: clear all five outputs and the internal run counter; latch remaining=window_len.
  - start=1 with window_len=0 is ignored; stay IDLE.
  - in_valid is ignored in IDLE.
  - Outputs hold the last report's values until the next accepted start.
- COLLECT: each edge with in_valid=1 is one sample.
  - Exactly one of gr/ls/eq high: increment the matching counter.
  - Any other encoding (000, 011, 101, 110, 111): increment cnt_err only.
  - Legal eq sample: run=run+1, and max_eq_run=max(max_eq_run, run+1) on the same edge.
  - Any other valid sample (including illegal encodings): run=0.
  - in_valid=0: no change; a gap does not break an eq run.
  - remaining decrements per sample. The sample taken at remaining==1 is the last; the same edge moves to REPORT.
  - report_valid=1 from the cycle after the last sample, i.e. latency 1 cycle.
  - start is ignored while in COLLECT.
- REPORT:
  - report_valid=1; all count outputs stable.
  - in_valid and start are ignored.
  - report_valid && report_ready at an edge -> IDLE; report_valid=0 next cycle. A start in that same cycle is ignored.
  - report_ready held high in advance gives a 1-cycle report pulse.
- Invariants:
  - No counter can overflow, since cnt_gr+cnt_ls+cnt_eq+cnt_err == window_len at report.
  - max_eq_run <= cnt_eq.
- busy=1 exactly while state is COLLECT or REPORT.

Test Plan:
- Reset check:
  - Assert rst 2 cycles -> all outputs 0, busy=0.
  - start with window_len=0 -> busy stays 0.
- Basic window:
  - window_len=5; samples gr,ls,eq,eq,gr with in_valid=1 back-to-back.
  - -> report_valid rises 1 cycle after 5th sample.
  - -> cnt_gr=2, cnt_ls=1, cnt_eq=2, cnt_err=0, max_eq_run=2.
- Illegal encodings and gaps:
  - window_len=6; samples eq, eq, (in_valid=0 for 3 cycles), eq, 110, eq, 000.
  - -> cnt_eq=4, cnt_err=2, max_eq_run=3.
  - -> in_valid=0 cycles are not counted.
- Handshake hold:
  - Hold report_ready=0 for 10 cycles after report_valid.
  - Toggle in_valid/start and flags during those cycles.
  - -> outputs unchanged, report_valid stays 1.
  - report_ready=1 -> IDLE next cycle, report fields retained.
- Full-scale window:
  - CW=8, window_len=255, all samples eq.
  - -> cnt_eq=255, max_eq_run=255, no wrap.
- Reset mid-operation:
  - rst during COLLECT after 3 of 8 samples -> IDLE, counts 0.
  - New start with window_len=2, samples ls,ls -> cnt_ls=2, others 0.
